// File: rtl/rp2serial_pkg.sv
// Shared state encoding and sizing helpers for the region-proposal serial transmitter.
package rp2serial_pkg;

  localparam int unsigned MaxNumObj = 8;
  localparam int unsigned XWidth    = 9;
  localparam int unsigned YWidth    = 9;
  localparam int unsigned GapCycles = 1;

  typedef enum logic [2:0] {
    StCollect,
    StReq,
    StShift,
    StGap,
    StEnd
  } tx_state_e;

  // Width able to hold 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width able to address n entries.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CntWidth = cnt_width(MaxNumObj);
  localparam int unsigned PtrWidth = ptr_width(MaxNumObj);

endpackage

// File: rtl/rp_list_buffer.sv
// Per-frame proposal list: one write port, one combinational indexed read port, sync clear.
module rp_list_buffer
  import rp2serial_pkg::*;
#(
  parameter int unsigned Depth     = MaxNumObj,
  parameter int unsigned Width     = XWidth + YWidth,
  parameter int unsigned AddrWidth = ptr_width(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rp2serial_tx.sv
// Collects a frame of (x,y) region proposals, then bursts them LSB-first on two 1-bit lanes.
module rp2serial_tx
  import rp2serial_pkg::*;
#(
  parameter int unsigned MAX_NUM_OBJ = MaxNumObj,
  parameter int unsigned X_WIDTH     = XWidth,
  parameter int unsigned Y_WIDTH     = YWidth,  // must equal X_WIDTH
  parameter int unsigned GAP_CYCLES  = GapCycles
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [X_WIDTH-1:0] rp_x,
  input  logic [Y_WIDTH-1:0] rp_y,
  input  logic               rp_we,
  input  logic               rp_frame_done,
  output logic               rp_ready,
  output logic               rp_overflow,
  input  logic               cnn_rd_region,
  output logic               cnn_region_done,
  output logic               cnn_region_valid,
  output logic               cnn_region_x_bit,
  output logic               cnn_region_y_bit,
  output logic               cnn_burst_en,
  output logic               tx_abort
);

  localparam int unsigned CntW   = cnt_width(MAX_NUM_OBJ);
  localparam int unsigned PtrW   = ptr_width(MAX_NUM_OBJ);
  localparam int unsigned EntryW = X_WIDTH + Y_WIDTH;
  localparam int unsigned BitW   = cnt_width(X_WIDTH);
  localparam int unsigned GapW   = cnt_width(GAP_CYCLES);

  tx_state_e          state_q, state_d;
  logic [CntW-1:0]    count_q, count_d, cnt_after;
  logic [CntW-1:0]    rd_ptr_q, rd_ptr_d, next_ptr;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [X_WIDTH-1:0] x_sh_q, x_sh_d, load_x;
  logic [Y_WIDTH-1:0] y_sh_q, y_sh_d, load_y;
  logic               overflow_q, overflow_d;
  logic               ready_q, ready_d, done_q, done_d, valid_q, valid_d;
  logic               xbit_q, xbit_d, ybit_q, ybit_d, burst_q, burst_d, abort_q, abort_d;
  logic               buf_we, buf_clr;
  logic [PtrW-1:0]    buf_raddr;
  logic [EntryW-1:0]  buf_rdata;

  rp_list_buffer #(
    .Depth     (MAX_NUM_OBJ),
    .Width     (EntryW),
    .AddrWidth (PtrW)
  ) u_list (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .waddr_i (count_q[PtrW-1:0]),
    .wdata_i ({rp_x, rp_y}),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  assign next_ptr  = rd_ptr_q + CntW'(1);
  // REQ always loads entry 0; GAP loads the entry after the one just sent.
  assign buf_raddr = (state_q == StReq) ? '0 : next_ptr[PtrW-1:0];
  assign load_x    = buf_rdata[EntryW-1:Y_WIDTH];
  assign load_y    = buf_rdata[Y_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cnt_after  = count_q;
    rd_ptr_d   = rd_ptr_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    x_sh_d     = x_sh_q;
    y_sh_d     = y_sh_q;
    overflow_d = overflow_q;
    xbit_d     = 1'b0;
    ybit_d     = 1'b0;
    abort_d    = 1'b0;
    buf_we     = 1'b0;
    buf_clr    = 1'b0;

    case (state_q)
      StCollect: begin
        if (rp_we) begin
          if (count_q < CntW'(MAX_NUM_OBJ)) begin
            buf_we    = 1'b1;
            cnt_after = count_q + CntW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        count_d = cnt_after;
        // A same-cycle write is counted before the frame closes.
        if (rp_frame_done) begin
          if (cnt_after != '0) state_d = StReq;
          else overflow_d = 1'b0;
        end
      end
      StReq: begin
        if (cnn_rd_region) begin
          state_d   = StShift;
          rd_ptr_d  = '0;
          bit_cnt_d = '0;
          x_sh_d    = load_x;
          y_sh_d    = load_y;
          xbit_d    = load_x[0];
          ybit_d    = load_y[0];
        end
      end
      StShift: begin
        if (!cnn_rd_region) begin
          abort_d = 1'b1;
        end else if (bit_cnt_q == BitW'(X_WIDTH - 1)) begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
          x_sh_d    = x_sh_q >> 1;
          y_sh_d    = y_sh_q >> 1;
          xbit_d    = x_sh_q[1];
          ybit_d    = y_sh_q[1];
        end
      end
      StGap: begin
        if (!cnn_rd_region) begin
          abort_d = 1'b1;
        end else if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          if (next_ptr < count_q) begin
            state_d   = StShift;
            rd_ptr_d  = next_ptr;
            bit_cnt_d = '0;
            x_sh_d    = load_x;
            y_sh_d    = load_y;
            xbit_d    = load_x[0];
            ybit_d    = load_y[0];
          end else begin
            state_d = StEnd;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StEnd: begin
        state_d    = StCollect;
        buf_clr    = 1'b1;
        count_d    = '0;
        rd_ptr_d   = '0;
        overflow_d = 1'b0;
      end
      default: state_d = StCollect;
    endcase

    if (abort_d) begin
      state_d    = StCollect;
      buf_clr    = 1'b1;
      count_d    = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end

    // Outputs are registered copies decoded from the next state.
    ready_d = (state_d == StCollect);
    done_d  = (state_d != StCollect);
    valid_d = (state_d == StShift);
    burst_d = (state_d == StShift) || (state_d == StGap);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StCollect;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      x_sh_q     <= '0;
      y_sh_q     <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      xbit_q     <= 1'b0;
      ybit_q     <= 1'b0;
      burst_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      x_sh_q     <= x_sh_d;
      y_sh_q     <= y_sh_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      xbit_q     <= xbit_d;
      ybit_q     <= ybit_d;
      burst_q    <= burst_d;
      abort_q    <= abort_d;
    end
  end

  assign rp_ready         = ready_q;
  assign rp_overflow      = overflow_q;
  assign cnn_region_done  = done_q;
  assign cnn_region_valid = valid_q;
  assign cnn_region_x_bit = xbit_q;
  assign cnn_region_y_bit = ybit_q;
  assign cnn_burst_en     = burst_q;
  assign tx_abort         = abort_q;

endmodule
